// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared widths, state encoding, special-case constants and the
//               result sign-fixup helper for the div32s16_seq divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int A_W = 32;
    localparam int B_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } div_state_t;

    localparam logic [A_W-1:0] DZ_QUOT  = {A_W{1'b1}};
    localparam logic [A_W-1:0] OVF_QUOT = {1'b1, {(A_W-1){1'b0}}};

    typedef struct packed {
        logic [A_W-1:0] quo;
        logic [B_W-1:0] rem;
    } div_result_t;

    // Magnitudes in, signed results out; special cases override the magnitudes.
    function automatic div_result_t div_finalize(
        input logic           dz,
        input logic           ovf,
        input logic           sign_q,
        input logic           sign_r,
        input logic [A_W-1:0] quo_mag,
        input logic [B_W-1:0] rem_mag,
        input logic [B_W-1:0] a_lo
    );
        div_result_t res;
        if (dz) begin
            res.quo = DZ_QUOT;
            res.rem = a_lo;
        end else if (ovf) begin
            res.quo = OVF_QUOT;
            res.rem = '0;
        end else begin
            res.quo = sign_q ? -quo_mag : quo_mag;
            res.rem = sign_r ? -rem_mag : rem_mag;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div32s16_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : div32s16_seq_if
// Description : Operand / result valid-ready bundle for the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface div32s16_seq_if #(
    parameter int A_W = div_pkg::A_W,
    parameter int B_W = div_pkg::B_W
);
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] in_dividend;
    logic [B_W-1:0] in_divisor;
    logic           out_valid;
    logic           out_ready;
    logic [A_W-1:0] out_quotient;
    logic [B_W-1:0] out_remainder;
    logic           out_div_by_zero;
    logic           out_overflow;

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder,
               out_div_by_zero, out_overflow
    );

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder,
               out_div_by_zero, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/div_restoring_step.sv
`default_nettype none
// ============================================================================
// Module      : div_restoring_step
// Description : One radix-2 restoring iteration: shift {rem, quo}, trial
//               subtract the divisor magnitude, keep the result if no borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module div_restoring_step
    import div_pkg::*;
#(
    parameter int A_W = div_pkg::A_W,
    parameter int B_W = div_pkg::B_W
) (
    input  wire logic [B_W:0]   rem_in,
    input  wire logic [A_W-1:0] quo_in,
    input  wire logic [B_W-1:0] divisor,
    output logic      [B_W:0]   rem_out,
    output logic      [A_W-1:0] quo_out
);
    localparam int RW = B_W + 1;
    localparam int SW = B_W + 2;

    logic [SW-1:0] w_shifted;
    logic [SW-1:0] w_dvs;
    logic          w_ge;

    assign w_shifted = {rem_in, quo_in[A_W-1]};
    assign w_dvs     = {2'b00, divisor};
    assign w_ge      = (w_shifted >= w_dvs);

    // The remainder stays below |B| <= 2^(B_W-1), so the truncation is lossless.
    assign rem_out = w_ge ? RW'(w_shifted - w_dvs) : RW'(w_shifted);
    assign quo_out = {quo_in[A_W-2:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/div32s16_seq.sv
`default_nettype none
// ============================================================================
// Module      : div32s16_seq
// Description : Iterative 32/16 signed restoring divider, one quotient bit per
//               cycle. DIV32S16_EARLY_EXIT_EN finishes trivial/special ops in 1.
// Revision    : 1.0 - initial release
// ============================================================================
module div32s16_seq
    import div_pkg::*;
(
    input wire logic          clk,
    input wire logic          rst_n,
    div32s16_seq_if.slave     bus
);
    localparam int CNT_W = $clog2(A_W + 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [B_W:0]     r_rem;
    logic [A_W-1:0]   r_quo;
    logic [B_W-1:0]   r_absb;
    logic [B_W-1:0]   r_a_lo;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dz;
    logic             r_ovf;
    logic             r_early;
    logic [A_W-1:0]   r_out_quo;
    logic [B_W-1:0]   r_out_rem;
    logic             r_out_dz;
    logic             r_out_ovf;

    logic             w_sign_a;
    logic             w_sign_b;
    logic [A_W-1:0]   w_abs_a;
    logic [B_W-1:0]   w_abs_b;
    logic             w_dz;
    logic             w_ovf;
    logic             w_early;
    logic [B_W:0]     w_rem_nxt;
    logic [A_W-1:0]   w_quo_nxt;
    logic [A_W-1:0]   w_fin_quo;
    logic [B_W-1:0]   w_fin_rem;
    div_result_t      w_res;

    assign w_sign_a = bus.in_dividend[A_W-1];
    assign w_sign_b = bus.in_divisor[B_W-1];
    assign w_abs_a  = w_sign_a ? -bus.in_dividend : bus.in_dividend;
    assign w_abs_b  = w_sign_b ? -bus.in_divisor  : bus.in_divisor;
    assign w_dz     = (bus.in_divisor == '0);
    assign w_ovf    = (bus.in_dividend == OVF_QUOT) && (bus.in_divisor == {B_W{1'b1}});

`ifdef DIV32S16_EARLY_EXIT_EN
    logic w_trivial;
    assign w_trivial = (w_abs_a < {{(A_W-B_W){1'b0}}, w_abs_b});
    assign w_early   = w_dz | w_ovf | w_trivial;
`else
    assign w_early   = 1'b0;
`endif

    div_restoring_step #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_absb),
        .rem_out (w_rem_nxt),
        .quo_out (w_quo_nxt)
    );

    // An early-exit op never iterates: quotient 0, remainder is |A| itself.
    assign w_fin_quo = r_early ? '0 : w_quo_nxt;
    assign w_fin_rem = r_early ? r_quo[B_W-1:0] : w_rem_nxt[B_W-1:0];
    assign w_res     = div_finalize(r_dz, r_ovf, r_sign_q, r_sign_r,
                                    w_fin_quo, w_fin_rem, r_a_lo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_absb    <= '0;
            r_a_lo    <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
            r_early   <= 1'b0;
            r_out_quo <= '0;
            r_out_rem <= '0;
            r_out_dz  <= 1'b0;
            r_out_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_quo    <= w_abs_a;
                        r_absb   <= w_abs_b;
                        r_rem    <= '0;
                        r_a_lo   <= bus.in_dividend[B_W-1:0];
                        r_sign_q <= w_sign_a ^ w_sign_b;
                        r_sign_r <= w_sign_a;
                        r_dz     <= w_dz;
                        r_ovf    <= w_ovf;
                        r_early  <= w_early;
                        r_cnt    <= CNT_W'(A_W);
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_early || r_cnt == CNT_W'(1)) begin
                        r_out_quo <= w_res.quo;
                        r_out_rem <= w_res.rem;
                        r_out_dz  <= r_dz;
                        r_out_ovf <= r_ovf;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_quo <= '0;
                        r_out_rem <= '0;
                        r_out_dz  <= 1'b0;
                        r_out_ovf <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready        = (r_state == S_IDLE);
    assign bus.out_valid       = (r_state == S_DONE);
    assign bus.out_quotient    = r_out_quo;
    assign bus.out_remainder   = r_out_rem;
    assign bus.out_div_by_zero = r_out_dz;
    assign bus.out_overflow    = r_out_ovf;

endmodule
`default_nettype wire
